mul_share_arbiter: RTL

Shares one sequential signed 16x16 shift-add multiply engine among NREQ requesters. Arbitration is round-robin, and each port uses a valid/ready handshake. The block sits between client blocks that need occasional products and replaces one combinational multiplier per client. It takes one operand pair at a time and computes the product over 16 shift-add cycles. It returns the 32-bit two's-complement result tagged with the requester index.

---
 rtl/mul_share_arbiter_if.sv | 28 ++
 rtl/mul_share_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle between the requesters and the shared multiply engine.
interface mul_share_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [16*NREQ-1:0]   req_a;
  logic [16*NREQ-1:0]   req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_product;
  logic                 busy;

  // Client side: issues operand pairs, consumes products.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product, busy
  );

  // Engine side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product, busy
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin shared sequential signed 16x16 multiplier (16 shift-add steps).
module mul_share_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mul_share_arbiter_if.slave   bus
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned OPW = 16;
  localparam int unsigned PW  = 32;
  localparam int unsigned CW  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id_q;
  logic [OPW-1:0]  a_abs;
  logic [OPW-1:0]  b_abs;
  logic            sign_q;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   prod_q;
  logic [CW-1:0]   cnt;
  logic            rsp_valid_q;
  logic            busy_q;

  logic            grant_any;
  logic [IDW-1:0]  grant_idx;
  logic [OPW-1:0]  grant_a;
  logic [OPW-1:0]  grant_b;
  logic [PW-1:0]   partial;
  logic [PW-1:0]   acc_next;

  // Magnitude of a two's-complement operand; -32768 maps to 0x8000.
  function automatic logic [OPW-1:0] abs_op(input logic [OPW-1:0] v);
    return v[OPW-1] ? (~v + OPW'(1)) : v;
  endfunction

  // Round-robin pick: first valid requester searching upward from ptr+1.
  always_comb begin
    int unsigned j;
    j         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_a   = '0;
    grant_b   = '0;
    if (state == ST_IDLE) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        j = 32'(ptr) + k;
        if (j >= NREQ) j = j - NREQ;
        if (!grant_any && bus.req_valid[IDW'(j)]) begin
          grant_any = 1'b1;
          grant_idx = IDW'(j);
          grant_a   = bus.req_a[OPW*j +: OPW];
          grant_b   = bus.req_b[OPW*j +: OPW];
        end
      end
    end
  end

  assign bus.req_ready = grant_any ? (NREQ'(1) << grant_idx) : '0;

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  assign partial  = b_abs[cnt] ? (PW'(a_abs) << cnt) : '0;
  assign acc_next = acc + partial;

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= IDW'(NREQ - 1);
      id_q        <= '0;
      a_abs       <= '0;
      b_abs       <= '0;
      sign_q      <= 1'b0;
      acc         <= '0;
      prod_q      <= '0;
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            a_abs  <= abs_op(grant_a);
            b_abs  <= abs_op(grant_b);
            sign_q <= grant_a[OPW-1] ^ grant_b[OPW-1];
            id_q   <= grant_idx;
            ptr    <= grant_idx;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_MUL;
          end
        end
        ST_MUL: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(OPW - 1)) begin
            prod_q      <= sign_q ? (~acc_next + PW'(1)) : acc_next;
            rsp_valid_q <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_product = prod_q;
  assign bus.busy        = busy_q;

endmodule
